// File: rtl/router_outp_demux.sv
// router_outp_demux: steers validated router packets into four per-DA
// output FIFOs, admitting a packet only when its whole length fits.
// Ports: clk, reset (async, active-high); in_data/in_valid byte stream;
// port_data/port_last/port_valid/port_ready per-port FWFT drain;
// pkt_drop_cnt, trunc_cnt, proto_err_cnt, port_pkt_cnt saturating status.
// Build option: define ROUTER_DEMUX_STATS_EN for per-port packet counters.
module router_outp_demux #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic [31:0]        port_data,
    output logic [3:0]         port_last,
    output logic [3:0]         port_valid,
    input  logic [3:0]         port_ready,
    output logic [CNT_W-1:0]   pkt_drop_cnt,
    output logic [CNT_W-1:0]   trunc_cnt,
    output logic [CNT_W-1:0]   proto_err_cnt,
    output logic [4*CNT_W-1:0] port_pkt_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE, HDR, FWD, DISCARD, FLUSH
    } state_t;

    state_t state, state_nx;

    logic [7:0]  dl_data [6];
    logic [5:0]  dl_vld;
    logic [2:0]  hdr_idx;
    logic [7:0]  da_q;
    logic [23:0] len_lo;
    logic [11:0] len_q;
    logic [11:0] rx_cnt;
    logic [11:0] push_idx;
    logic [1:0]  port_q;
    logic        extra_seen;
    logic        rise_seen;

    logic [AW:0]   cnt    [4];
    logic [AW-1:0] wr_ptr [4];
    logic [AW-1:0] rd_ptr [4];
    logic [8:0]    mem    [4][DEPTH];

    logic        take, line_clr, admit;
    logic        drop_inc, perr_inc;
    logic        push, push_last, trunc, more, is_len_end;
    logic [3:0]  push_vec, pop_vec;
    logic [31:0] len_full;
    logic [1:0]  da_port;
    logic [AW:0] free_sel;
    logic        da_ok, len_ok, space_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Admission is judged on the edge that samples byte 5 (LEN MSB).
    assign len_full = {in_data, len_lo};
    assign da_ok    = (da_q >= 8'd1) && (da_q <= 8'd4);
    assign da_port  = 2'(da_q - 8'd1);
    assign free_sel = (AW+1)'(DEPTH) - cnt[da_port];
    assign len_ok   = (len_full >= 32'd12) && (len_full <= 32'd2001);
    assign space_ok = len_full <= 32'(free_sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        line_clr = 1'b0;
        admit    = 1'b0;
        drop_inc = 1'b0;
        perr_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    take     = 1'b1;
                    state_nx = HDR;
                end
            end
            HDR: begin
                if (!in_valid) begin
                    drop_inc = 1'b1;
                    line_clr = 1'b1;
                    state_nx = IDLE;
                end else if (hdr_idx == 3'd5) begin
                    if (da_ok && len_ok && space_ok) begin
                        take     = 1'b1;
                        admit    = 1'b1;
                        state_nx = FWD;
                    end else begin
                        drop_inc = 1'b1;
                        line_clr = 1'b1;
                        state_nx = DISCARD;
                    end
                end else begin
                    take = 1'b1;
                end
            end
            FWD: begin
                if (!in_valid) begin
                    state_nx = FLUSH;
                end else if (rx_cnt < len_q) begin
                    take = 1'b1;
                end else if (!extra_seen) begin
                    perr_inc = 1'b1;
                end
            end
            DISCARD: begin
                if (!in_valid) state_nx = IDLE;
            end
            FLUSH: begin
                if (in_valid && !rise_seen) perr_inc = 1'b1;
                // A new packet overlapping the flush is not trusted.
                if (dl_vld[4:0] == 5'd0)
                    state_nx = in_valid ? DISCARD : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Head of the line is written while forwarding; a head with nothing
    // younger behind it and short of LEN closes a truncated packet.
    assign push       = dl_vld[5] && (state == FWD || state == FLUSH);
    assign more       = take || (dl_vld[4:0] != 5'd0);
    assign is_len_end = push_idx == (len_q - 12'd1);
    assign trunc      = push && !more && !is_len_end;
    assign push_last  = is_len_end || trunc;

    always_comb begin
        for (int p = 0; p < 4; p++)
            push_vec[p] = push && (port_q == 2'(p));
    end

    assign pop_vec = port_valid & port_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) dl_data[i] <= '0;
            dl_vld        <= '0;
            hdr_idx       <= '0;
            da_q          <= '0;
            len_lo        <= '0;
            len_q         <= '0;
            rx_cnt        <= '0;
            push_idx      <= '0;
            port_q        <= '0;
            extra_seen    <= 1'b0;
            rise_seen     <= 1'b0;
            pkt_drop_cnt  <= '0;
            trunc_cnt     <= '0;
            proto_err_cnt <= '0;
        end else begin
            dl_data[0] <= in_data;
            for (int i = 1; i < 6; i++) dl_data[i] <= dl_data[i-1];
            dl_vld <= line_clr ? 6'd0 : {dl_vld[4:0], take};

            if (state == IDLE && in_valid) begin
                hdr_idx <= 3'd1;
            end else if (state == HDR && in_valid && hdr_idx != 3'd5) begin
                hdr_idx <= hdr_idx + 3'd1;
                unique case (hdr_idx)
                    3'd1:    da_q         <= in_data;
                    3'd2:    len_lo[7:0]   <= in_data;
                    3'd3:    len_lo[15:8]  <= in_data;
                    3'd4:    len_lo[23:16] <= in_data;
                    default: ;
                endcase
            end

            if (admit) begin
                len_q      <= len_full[11:0];
                port_q     <= da_port;
                rx_cnt     <= 12'd6;
                push_idx   <= '0;
                extra_seen <= 1'b0;
            end else begin
                if (state == FWD && take) rx_cnt <= rx_cnt + 12'd1;
                if (state == FWD && perr_inc) extra_seen <= 1'b1;
                if (push) push_idx <= push_idx + 12'd1;
            end

            if (state != FLUSH) rise_seen <= 1'b0;
            else if (in_valid)  rise_seen <= 1'b1;

            if (drop_inc) pkt_drop_cnt  <= sat_inc(pkt_drop_cnt);
            if (trunc)    trunc_cnt     <= sat_inc(trunc_cnt);
            if (perr_inc) proto_err_cnt <= sat_inc(proto_err_cnt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 4; p++) begin
                cnt[p]    <= '0;
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (push_vec[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
                if (pop_vec[p])  rd_ptr[p] <= rd_ptr[p] + AW'(1);
                cnt[p] <= cnt[p] + (AW+1)'(push_vec[p])
                                 - (AW+1)'(pop_vec[p]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 4; p++)
            if (push_vec[p]) mem[p][wr_ptr[p]] <= {push_last, dl_data[5]};
    end

    // First-word fall-through; outputs forced to zero while empty.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            port_valid[p]       = cnt[p] != '0;
            port_data[8*p +: 8] = (cnt[p] != '0) ? mem[p][rd_ptr[p]][7:0]
                                                 : 8'd0;
            port_last[p]        = (cnt[p] != '0) && mem[p][rd_ptr[p]][8];
        end
    end

`ifdef ROUTER_DEMUX_STATS_EN
    logic [CNT_W-1:0] pkt_cnt [4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 4; p++) pkt_cnt[p] <= '0;
        end else begin
            for (int p = 0; p < 4; p++)
                if (pop_vec[p] && port_last[p])
                    pkt_cnt[p] <= sat_inc(pkt_cnt[p]);
        end
    end

    always_comb begin
        for (int p = 0; p < 4; p++)
            port_pkt_cnt[p*CNT_W +: CNT_W] = pkt_cnt[p];
    end
`else
    assign port_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_router_outp_demux.sv
// tb_router_outp_demux: directed and random packets against a
// packet-level reference model with per-port expected byte queues.
module tb_router_outp_demux;
    localparam int DEPTH = 32;
    localparam int CNT_W = 16;
`ifdef ROUTER_DEMUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic               clk;
    logic               reset;
    logic [7:0]         in_data;
    logic               in_valid;
    logic [31:0]        port_data;
    logic [3:0]         port_last;
    logic [3:0]         port_valid;
    logic [3:0]         port_ready;
    logic [CNT_W-1:0]   pkt_drop_cnt;
    logic [CNT_W-1:0]   trunc_cnt;
    logic [CNT_W-1:0]   proto_err_cnt;
    logic [4*CNT_W-1:0] port_pkt_cnt;

    router_outp_demux #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .port_data    (port_data),
        .port_last    (port_last),
        .port_valid   (port_valid),
        .port_ready   (port_ready),
        .pkt_drop_cnt (pkt_drop_cnt),
        .trunc_cnt    (trunc_cnt),
        .proto_err_cnt(proto_err_cnt),
        .port_pkt_cnt (port_pkt_cnt)
    );

    typedef logic [8:0] ent_t;
    ent_t exp_q [4][$];
    int   exp_ppc [4];
    int   exp_drop, exp_trunc, exp_perr;
    int   n_err, n_checks;
    bit   rand_rdy;
    logic [3:0] fixed_rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        port_ready = rand_rdy ? 4'($urandom) : fixed_rdy;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Consumer-side monitor: every pop must match the model's next entry,
    // and a port with nothing expected must never show valid.
    always @(negedge clk) begin
        if (!reset) begin
            for (int p = 0; p < 4; p++) begin
                if (exp_q[p].size() == 0) begin
                    n_checks++;
                    assert (port_valid[p] === 1'b0) else begin
                        n_err++;
                        $error("FAIL unexpected_valid port=%0d observed=%b expected=0",
                               p, port_valid[p]);
                    end
                end else if (port_valid[p] && port_ready[p]) begin
                    ent_t e;
                    e = exp_q[p].pop_front();
                    n_checks++;
                    assert ({port_last[p], port_data[p*8 +: 8]} === e) else begin
                        n_err++;
                        $error("FAIL beat port=%0d observed=%h expected=%h",
                               p, {port_last[p], port_data[p*8 +: 8]}, e);
                    end
                    if (e[8]) exp_ppc[p]++;
                end
            end
        end
    end

    function automatic int qtotal();
        return exp_q[0].size() + exp_q[1].size()
             + exp_q[2].size() + exp_q[3].size();
    endfunction

    task automatic mk(output logic [7:0] b[$], input int da, input int len,
                      input int n);
        int nb;
        nb = (n > 10) ? n : 10;
        b = {};
        for (int k = 0; k < nb; k++) b.push_back(8'($urandom));
        b[1] = 8'(da);
        b[2] = 8'(len);
        b[3] = 8'(len >> 8);
        b[4] = 8'(len >> 16);
        b[5] = 8'(len >> 24);
    endtask

    // Packet-level model: whole-packet admission, then the bytes that
    // reach the port, with last on the final delivered byte.
    task automatic predict(input logic [7:0] b[$], input int n);
        int da, len, p, nf;
        if (n < 6) begin
            exp_drop++;
            return;
        end
        da  = int'(b[1]);
        len = int'({b[5], b[4], b[3], b[2]});
        if (da < 1 || da > 4 || len < 12 || len > 2001) begin
            exp_drop++;
            return;
        end
        p = da - 1;
        if (len > DEPTH - exp_q[p].size()) begin
            exp_drop++;
            return;
        end
        nf = (n < len) ? n : len;
        for (int k = 0; k < nf; k++)
            exp_q[p].push_back({(k == nf - 1), b[k]});
        if (n < len) exp_trunc++;
        if (n > len) exp_perr++;
    endtask

    task automatic drive(input logic [7:0] b[$], input int n);
        for (int k = 0; k < n; k++) begin
            in_data  = b[k];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 8'd0;
    endtask

    task automatic settle(input bit drain);
        int g;
        repeat (10) @(posedge clk);
        #1;
        if (drain) begin
            g = 0;
            while (qtotal() != 0 && g < 2000) begin
                @(posedge clk);
                #1;
                g++;
            end
            chk("drain", 32'(qtotal()), 32'd0);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_drop"},  32'(pkt_drop_cnt),  32'(exp_drop));
        chk({tag, "_trunc"}, 32'(trunc_cnt),     32'(exp_trunc));
        chk({tag, "_perr"},  32'(proto_err_cnt), 32'(exp_perr));
    endtask

    task automatic chk_ppc(input string tag);
        for (int p = 0; p < 4; p++)
            chk(tag, 32'(port_pkt_cnt[p*CNT_W +: CNT_W]),
                STATS ? 32'(exp_ppc[p]) : 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b[$];
        logic [7:0] b2[$];
        int sel, da, len, n;

        n_err = 0; n_checks = 0;
        exp_drop = 0; exp_trunc = 0; exp_perr = 0;
        for (int p = 0; p < 4; p++) exp_ppc[p] = 0;
        rand_rdy  = 1'b0;
        fixed_rdy = 4'hF;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        chk("rst_valid", 32'(port_valid), 32'd0);
        chk("rst_data",  port_data, 32'd0);
        chk("rst_last",  32'(port_last), 32'd0);
        chk_cnt("rst");
        chk_ppc("rst_ppc");

        // 12-byte packet to DA=2: first word visible right after E6.
        mk(b, 2, 12, 12);
        predict(b, 12);
        for (int k = 0; k < 12; k++) begin
            in_data  = b[k];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            if (k == 5) chk("t1_pre_valid", 32'(port_valid), 32'd0);
            if (k == 6) begin
                chk("t1_first_valid", 32'(port_valid), 32'h2);
                chk("t1_first_data", 32'(port_data[15:8]), 32'(b[0]));
            end
        end
        in_valid = 1'b0;
        settle(1'b1);
        chk_cnt("t1");

        // Bad DA.
        mk(b, 5, 20, 20);
        predict(b, 20);
        drive(b, 20);
        settle(1'b1);
        chk_cnt("bad_da");

        // Space check with port 0 stalled: 20 fits, 20 more does not,
        // 12 exactly fills the remaining space.
        fixed_rdy = 4'hE;
        repeat (2) @(posedge clk);
        #1;
        mk(b, 1, 20, 20);
        predict(b, 20);
        drive(b, 20);
        settle(1'b0);
        mk(b2, 1, 20, 20);
        predict(b2, 20);
        drive(b2, 20);
        settle(1'b0);
        chk_cnt("full");
        chk("full_head_valid", 32'(port_valid[0]), 32'd1);
        chk("full_head_data", 32'(port_data[7:0]), 32'(b[0]));
        mk(b2, 1, 12, 12);
        predict(b2, 12);
        drive(b2, 12);
        settle(1'b0);
        chk_cnt("exact_fit");
        fixed_rdy = 4'hF;
        settle(1'b1);

        // Truncation, extra bytes, short header, length bounds.
        mk(b, 3, 30, 20);
        predict(b, 20);
        drive(b, 20);
        settle(1'b1);
        chk_cnt("trunc");

        mk(b, 4, 14, 17);
        predict(b, 17);
        drive(b, 17);
        settle(1'b1);
        chk_cnt("extra");

        mk(b, 1, 20, 4);
        predict(b, 4);
        drive(b, 4);
        settle(1'b1);
        chk_cnt("short_hdr");

        mk(b, 2, 11, 11);
        predict(b, 11);
        drive(b, 11);
        settle(1'b1);
        mk(b, 2, 40, 40);
        predict(b, 40);
        drive(b, 40);
        settle(1'b1);
        mk(b, 2, 32, 32);
        predict(b, 32);
        drive(b, 32);
        settle(1'b1);
        chk_cnt("len_bounds");

        // New packet starting while the previous one is still flushing.
        mk(b, 1, 12, 12);
        predict(b, 12);
        drive(b, 12);
        @(posedge clk);
        #1;
        mk(b2, 2, 12, 12);
        exp_perr++;
        drive(b2, 12);
        settle(1'b1);
        chk_cnt("flush_rise");

        // Reset in the middle of an admitted packet.
        fixed_rdy = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        mk(b, 3, 30, 30);
        predict(b, 30);
        drive(b, 8);
        reset = 1'b1;
        #1;
        for (int p = 0; p < 4; p++) begin
            exp_q[p].delete();
            exp_ppc[p] = 0;
        end
        exp_drop = 0; exp_trunc = 0; exp_perr = 0;
        chk("midrst_valid", 32'(port_valid), 32'd0);
        chk("midrst_data", port_data, 32'd0);
        chk_cnt("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("postrst_valid", 32'(port_valid), 32'd0);
        chk("postrst_last", 32'(port_last), 32'd0);
        fixed_rdy = 4'hF;

        // One packet to each port.
        for (int d = 1; d <= 4; d++) begin
            mk(b, d, 12 + d, 12 + d);
            predict(b, 12 + d);
            drive(b, 12 + d);
            settle(1'b1);
        end
        chk_cnt("four");
        chk_ppc("four_ppc");

        // Random packets with random consumer back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            da  = $urandom_range(1, 4);
            len = $urandom_range(12, 32);
            if (sel == 0) da = $urandom_range(0, 1) ? 0 : $urandom_range(5, 255);
            if (sel == 1) len = $urandom_range(5, 11);
            if (sel == 2) len = $urandom_range(33, 40);
            n = len;
            if (sel == 3) n = $urandom_range(6, len - 1);
            if (sel == 4) n = len + $urandom_range(1, 3);
            if (sel == 5) n = $urandom_range(1, 5);
            mk(b, da, len, n);
            predict(b, n);
            drive(b, n);
            settle(1'b1);
            chk_cnt("rand");
        end
        rand_rdy = 1'b0;
        settle(1'b1);
        chk_ppc("final_ppc");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/router_outp_demux.md
# router_outp_demux

Downstream stage of the router: consumes the validated byte stream the router drives on `dut_outp`/`outp_valid` and steers each packet into one of four per-destination output FIFOs selected by the DA byte. Packets are admitted only if their whole length fits in the target FIFO, so a packet is never split by overflow. Each output port drains through a valid/ready handshake with a `last` marker on the final byte.

## Interface
- `DEPTH`, 256: entries per port FIFO (power of two, ≥16); each entry is {last, byte}.
- `CNT_W`, 16: width of status counters (saturating).

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `in_data`  in  8  byte from the router's `dut_outp`.
- `in_valid`  in  1  from the router's `outp_valid`; high for one contiguous run per packet.
- `port_data`  out  32  byte for port p at [8p+7:8p].
- `port_last`  out  4  final byte of packet on port p.
- `port_valid`  out  4  port p FIFO non-empty.
- `port_ready`  in  4  consumer accepts port p head.
- `pkt_drop_cnt`  out  CNT_W  packets discarded (bad DA, bad length, no space, short header).
- `trunc_cnt`  out  CNT_W  admitted packets ended before `len` bytes.
- `proto_err_cnt`  out  CNT_W  extra bytes beyond `len` or `in_valid` rising during FLUSH.
- `port_pkt_cnt`  out  4*CNT_W  packets completed per port (see Configuration).

## Operation
- Packet format: byte0 SA, byte1 DA, bytes2-5 LEN little-endian ({b5,b4,b3,b2} = total bytes incl. header), bytes6-9 CRC, payload. Forwarded unmodified.
- Port index = DA−1; valid DA is 1..4.
- 6-entry delay line: every sampled byte enters the tail; the head is written to FIFO[port] six edges later, once admission is known.
- FSM:
  - IDLE: `in_valid`=1 → HDR, capture byte0.
  - HDR: capture bytes 1-5. `in_valid` low before byte5 → pkt_drop_cnt++, clear line, IDLE. At byte5: admit if DA∈1..4, 12≤LEN≤2001, LEN ≤ free entries of FIFO[DA−1] → FWD; otherwise pkt_drop_cnt++ → DISCARD.
  - FWD: push one byte per cycle; byte index LEN−1 pushed with last=1. Bytes after LEN−1 while `in_valid`=1 are discarded, proto_err_cnt++ once per packet. `in_valid` low → FLUSH.
  - DISCARD: ignore bytes until `in_valid` low → IDLE; no FIFO writes.
  - FLUSH: drain remaining delay-line entries; if `in_valid` dropped before LEN bytes, youngest real byte gets last=1 and trunc_cnt++. Empty → IDLE. `in_valid` high in FLUSH → proto_err_cnt++, that packet discarded (DISCARD after flush).
- Free-space check uses occupancy at byte5 edge; concurrent pops only add space, so admitted packets never overflow.
- LEN > DEPTH always dropped.
- Counters saturate at all-ones.

## Timing
- Reset: FIFOs empty, `port_valid`=0, `port_data`=0, `port_last`=0, all counters 0, FSM IDLE, delay line cleared. Reset mid-packet discards all partial state; no output after release until a new packet.
- Byte k sampled at edge Ek is written to FIFO at edge E(k+6); `port_valid` rises after E6 (first-word fall-through).
- Pop on `port_valid & port_ready`; data/last of next entry valid the following cycle.
- Simultaneous push and pop on the same FIFO: both occur; occupancy unchanged.
- Full FIFO: never written (guaranteed by admission). Empty + ready: no pop, `port_valid`=0.
- Upstream gap ≥7 idle cycles between packets; violation handled as above.

## Configuration
- `ROUTER_DEMUX_STATS_EN`: defined → `port_pkt_cnt[p]` increments on each last=1 pop on port p (saturating). Undefined → counters not built, `port_pkt_cnt` tied to 0; all other behaviour identical.

## Test plan
- 12-byte packet DA=2, LEN=12, `port_ready`=1 → bytes appear on port 1 from E6, 12 consecutive beats, last on 12th; pkt_drop_cnt=0.
- DA=5, LEN=20 → no port_valid ever; pkt_drop_cnt=1.
- DEPTH=16, port 0 ready=0, send LEN=12 then LEN=12 to DA=1 → first stored, second dropped (free=4); pkt_drop_cnt=1; raising ready yields exactly 12 bytes with one last.
- LEN=30 DA=3 but `in_valid` drops after 20 bytes → 20 bytes on port 2, last on 20th; trunc_cnt=1.
- Reset asserted at byte 8 of LEN=40 packet → all outputs 0; next valid packet forwards normally.
- Four packets to DA 1,2,3,4 with stats enabled → port_pkt_cnt each =1 after drain; without macro all 0.
